// File: rtl/timer_scheduler.sv
// Four-channel tick timer sharing one prescaler; each channel counts base ticks
// down from a loaded value and pulses expire on reaching zero (one-shot or periodic).
module timer_scheduler #(
    parameter int DIVISOR = 500000,
    parameter int CNT_W   = 28,
    parameter int LOAD_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            i_start,
    input  logic [3:0]            i_stop,
    input  logic [3:0]            i_periodic,
    input  logic [4*LOAD_W-1:0]   i_load,
    output logic [3:0]            o_busy,
    output logic [3:0]            o_expire,
    output logic                  o_tick
);
    localparam int NCH = 4;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            r_state    [NCH];
    state_t            w_state_nx [NCH];
    logic [LOAD_W-1:0] r_rem      [NCH];
    logic [LOAD_W-1:0] w_rem_nx   [NCH];
    logic [LOAD_W-1:0] r_load_q   [NCH];
    logic [LOAD_W-1:0] w_load_q_nx[NCH];
    logic [LOAD_W-1:0] w_eff      [NCH];
    logic [NCH-1:0]    r_mode;
    logic [NCH-1:0]    w_mode_nx;
    logic [NCH-1:0]    w_exp_nx;
    logic [NCH-1:0]    w_busy_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_tflag;

    assign w_tflag = (r_cnt == CNT_W'(DIVISOR - 1));

    // A zero load would never expire, so it is promoted to one tick.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign w_eff[g]     = (i_load[g*LOAD_W +: LOAD_W] == '0) ? LOAD_W'(1)
                                                                 : i_load[g*LOAD_W +: LOAD_W];
        assign o_busy[g]    = (r_state[g] == RUN);
        assign w_busy_nx[g] = (w_state_nx[g] == RUN);
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_state_nx[i]  = r_state[i];
            w_rem_nx[i]    = r_rem[i];
            w_load_q_nx[i] = r_load_q[i];
            w_mode_nx[i]   = r_mode[i];
            w_exp_nx[i]    = 1'b0;
            if (i_stop[i]) begin
                w_state_nx[i] = IDLE;
                w_rem_nx[i]   = '0;
            end else if (i_start[i]) begin
                w_state_nx[i]  = RUN;
                w_rem_nx[i]    = w_eff[i];
                w_load_q_nx[i] = w_eff[i];
                w_mode_nx[i]   = i_periodic[i];
            end else if (w_tflag && r_state[i] == RUN) begin
                if (r_rem[i] > LOAD_W'(1)) begin
                    w_rem_nx[i] = r_rem[i] - 1'b1;
                end else begin
                    w_exp_nx[i] = 1'b1;
                    if (r_mode[i]) begin
                        w_rem_nx[i] = r_load_q[i];
                    end else begin
                        w_state_nx[i] = IDLE;
                        w_rem_nx[i]   = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i]  <= IDLE;
                r_rem[i]    <= '0;
                r_load_q[i] <= '0;
            end
            r_mode   <= '0;
            o_expire <= '0;
            o_tick   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i]  <= w_state_nx[i];
                r_rem[i]    <= w_rem_nx[i];
                r_load_q[i] <= w_load_q_nx[i];
            end
            r_mode   <= w_mode_nx;
            o_expire <= w_exp_nx;
            o_tick   <= w_tflag;
        end
    end

    // Hold phase at 0 on the edge a first channel starts, and clear it on the
    // edge the last channel leaves, so an idle restart always sees a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_busy_nx == '0 || o_busy == '0 || w_tflag) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_timer_scheduler.sv
// Randomised + directed bench for timer_scheduler: a tick-level reference model
// predicts busy/expire/tick per cycle into a queue that a monitor drains.
module tb_timer_scheduler;
    localparam int D  = 4;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    start = '0, stop = '0, periodic = '0;
    logic [4*LW-1:0] load = '0;
    logic [3:0]    busy, expire;
    logic          tick;

    int checks = 0;
    int errors = 0;
    logic [8:0] expq[$];

    timer_scheduler #(.DIVISOR(D), .CNT_W(28), .LOAD_W(LW)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_stop(stop),
        .i_periodic(periodic), .i_load(load),
        .o_busy(busy), .o_expire(expire), .o_tick(tick)
    );

    always #5 clk = ~clk;

    // Reference model: each channel is "ticks left" plus a reload value; the
    // prescaler is the number of cycles elapsed in the current base period.
    bit m_run [4];
    bit m_per [4];
    int m_left[4];
    int m_n   [4];
    int m_age;

    always @(posedge clk) begin
        bit        was_active, now_active, tk;
        logic [3:0] e, b;
        int        n;
        e = '0;
        b = '0;
        tk = 1'b0;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_run[i] = 0; m_left[i] = 0;
            end
            m_age = 0;
        end else begin
            was_active = m_run[0] | m_run[1] | m_run[2] | m_run[3];
            tk = was_active && (m_age == D - 1);
            for (int i = 0; i < 4; i++) begin
                n = int'(load[i*LW +: LW]);
                if (n == 0) n = 1;
                if (stop[i]) begin
                    m_run[i] = 0; m_left[i] = 0;
                end else if (start[i]) begin
                    m_run[i] = 1; m_left[i] = n; m_n[i] = n; m_per[i] = periodic[i];
                end else if (tk && m_run[i]) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        e[i] = 1'b1;
                        if (m_per[i]) m_left[i] = m_n[i];
                        else m_run[i] = 0;
                    end
                end
            end
            now_active = m_run[0] | m_run[1] | m_run[2] | m_run[3];
            if (!now_active || !was_active) m_age = 0;
            else m_age = (m_age + 1) % D;
        end
        for (int i = 0; i < 4; i++) b[i] = m_run[i];
        expq.push_back({b, e, tk});
    end

    // Monitor: every cycle the DUT presents a fresh output triple.
    always @(negedge clk) begin
        logic [8:0] exp_v;
        if (expq.size() != 0) begin
            exp_v = expq.pop_front();
            checks++;
            if ({busy, expire, tick} !== exp_v) begin
                errors++;
                $display("FAIL cycle-out t=%0t busy/exp/tick got %b/%b/%b want %b/%b/%b",
                         $time, busy, expire, tick, exp_v[8:5], exp_v[4:1], exp_v[0]);
            end
        end
    end

    task automatic drive(input logic [3:0] s, input logic [3:0] p, input logic [3:0] per,
                         input int l0, input int l1, input int l2, input int l3);
        @(negedge clk); #2;
        start = s; stop = p; periodic = per;
        load = {LW'(l3), LW'(l2), LW'(l1), LW'(l0)};
    endtask

    task automatic pulse(input logic [3:0] s, input logic [3:0] p, input logic [3:0] per,
                         input int l0, input int l1, input int l2, input int l3);
        drive(s, p, per, l0, l1, l2, l3);
        drive('0, '0, '0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #2;
            start = '0; stop = '0;
        end
    endtask

    initial begin
        // Reset held with all starts requested: nothing may leave reset.
        rst = 1'b1;
        drive(4'hF, 4'h0, 4'h0, 3, 3, 3, 3);
        idle(3);
        @(negedge clk); #2;
        start = '0; rst = 1'b0;

        // One-shot ch0, load 3: expire after 12 cycles, ticks stop afterwards.
        pulse(4'h1, 4'h0, 4'h0, 3, 0, 0, 0);
        idle(18);

        // Periodic ch1, load 2: five periods, then cancel.
        pulse(4'h2, 4'h0, 4'h2, 0, 2, 0, 0);
        idle(41);
        pulse(4'h0, 4'h2, 4'h0, 0, 0, 0, 0);
        idle(10);

        // Zero load behaves as one tick.
        pulse(4'h4, 4'h0, 4'h0, 0, 0, 0, 0);
        idle(8);

        // Retrigger ch2 exactly on its expiry edge (load 2 -> expires 8 edges later).
        pulse(4'h4, 4'h0, 4'h4, 0, 0, 2, 0);
        idle(6);
        pulse(4'h4, 4'h0, 4'h4, 0, 0, 2, 0);
        idle(4);
        // start3 with stop3 together: stop wins.
        pulse(4'h8, 4'h8, 4'h0, 0, 0, 0, 5);
        idle(12);
        pulse(4'h0, 4'h4, 4'h0, 0, 0, 0, 0);
        idle(4);

        // ch0 and ch1 expiring in the same cycle.
        pulse(4'h3, 4'h0, 4'h0, 2, 2, 0, 0);
        idle(12);

        // Reset mid-count with ch0 and ch3 running.
        pulse(4'h9, 4'h0, 4'h0, 5, 0, 0, 5);
        idle(7);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, expire, tick} !== 9'b0) begin
            errors++;
            $display("FAIL async-reset got %b/%b/%b want 0/0/0", busy, expire, tick);
        end
        idle(2);
        @(negedge clk); #2;
        rst = 1'b0;
        idle(30);

        // Random phase.
        for (int k = 0; k < 400; k++) begin
            logic [3:0] s, p;
            s = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            p = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            drive(s, p, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 4), $urandom_range(0, 4));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 6));
        end
        idle(60);

        @(negedge clk); #2;
        checks++;
        if (expq.size() > 1) begin
            errors++;
            $display("FAIL queue-drain got %0d pending want <=1", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
